// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 32x32 register file with write-through bypass and pending-write scoreboard
module regfile_sb #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int PW   = 2
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    WEN,
  input  logic [$clog2(NREG)-1:0] wsel,
  input  logic [DW-1:0]           wdat,
  input  logic [$clog2(NREG)-1:0] rsel1,
  input  logic [$clog2(NREG)-1:0] rsel2,
  output logic [DW-1:0]           rdat1,
  output logic [DW-1:0]           rdat2,
  input  logic                    issue_en,
  input  logic                    issue_wr,
  input  logic [$clog2(NREG)-1:0] issue_dst,
  input  logic                    sb_clr,
  output logic                    stall,
  output logic                    sb_err
);

  localparam int SW = $clog2(NREG);
  localparam logic [PW-1:0] CNT_MAX = {PW{1'b1}};
  localparam logic [PW-1:0] CNT_ONE = PW'(1);

  logic [DW-1:0]   regs [NREG];
  logic [PW-1:0]   cnt  [NREG];
  logic [NREG-1:0] inc_vec;
  logic [NREG-1:0] dec_vec;
  logic            haz1;
  logic            haz2;

  // Architectural array; register 0 is never written so it stays 0
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (WEN && wsel != '0) begin
      regs[wsel] <= wdat;
    end
  end

  // Per-register issue (increment) and write-back (decrement) strobes
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_vec[r] = issue_en && issue_wr && (issue_dst == SW'(r));
      dec_vec[r] = WEN && (wsel == SW'(r));
    end
  end

  // Pending-write counters; flush wins, saturate and flag on over/underflow
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      sb_err <= 1'b0;
    end else if (sb_clr) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          if (cnt[r] == CNT_MAX) sb_err <= 1'b1;
          else                   cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec_vec[r] && !inc_vec[r]) begin
          if (cnt[r] == '0) sb_err <= 1'b1;
          else              cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  // Read ports: reg 0 reads 0, same-cycle write-back is forwarded
  always_comb begin
    rdat1 = '0;
    rdat2 = '0;
    if (rsel1 != '0) rdat1 = (WEN && wsel == rsel1) ? wdat : regs[rsel1];
    if (rsel2 != '0) rdat2 = (WEN && wsel == rsel2) ? wdat : regs[rsel2];
  end

  // RAW hazard: a sole pending writer retiring this cycle is covered by the bypass
  always_comb begin
    haz1  = (rsel1 != '0) && (cnt[rsel1] != '0) && !((cnt[rsel1] == CNT_ONE) && dec_vec[rsel1]);
    haz2  = (rsel2 != '0) && (cnt[rsel2] != '0) && !((cnt[rsel2] == CNT_ONE) && dec_vec[rsel2]);
    stall = haz1 || haz2;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed plus randomized check of regfile_sb against a reference model
module tb_regfile_sb;

  logic        CLK;
  logic        nRST;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic [4:0]  rsel1;
  logic [4:0]  rsel2;
  logic [31:0] rdat1;
  logic [31:0] rdat2;
  logic        issue_en;
  logic        issue_wr;
  logic [4:0]  issue_dst;
  logic        sb_clr;
  logic        stall;
  logic        sb_err;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_reg [32];
  int          m_cnt [32];
  bit          m_err;

  regfile_sb #(.DW(32), .NREG(32), .PW(2)) dut (
    .CLK(CLK), .nRST(nRST), .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1), .rdat2(rdat2),
    .issue_en(issue_en), .issue_wr(issue_wr), .issue_dst(issue_dst),
    .sb_clr(sb_clr), .stall(stall), .sb_err(sb_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int sel);
    if (sel == 0) return 32'h0;
    if (WEN && int'(wsel) == sel) return wdat;
    return m_reg[sel];
  endfunction

  function automatic bit exp_haz(input int sel);
    if (sel == 0 || m_cnt[sel] == 0) return 1'b0;
    if (m_cnt[sel] == 1 && WEN && int'(wsel) == sel) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_reg[r] = 32'h0;
      m_cnt[r] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_tick();
    int ir;
    int dr;
    if (!nRST) begin
      model_reset();
      return;
    end
    if (WEN && wsel != 5'd0) m_reg[wsel] = wdat;
    if (sb_clr) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      return;
    end
    ir = (issue_en && issue_wr && issue_dst != 5'd0) ? int'(issue_dst) : -1;
    dr = (WEN && wsel != 5'd0) ? int'(wsel) : -1;
    if (ir >= 0 && ir == dr) return;
    if (ir >= 0) begin
      if (m_cnt[ir] == 3) m_err = 1'b1;
      else m_cnt[ir] = m_cnt[ir] + 1;
    end
    if (dr >= 0) begin
      if (m_cnt[dr] == 0) m_err = 1'b1;
      else m_cnt[dr] = m_cnt[dr] - 1;
    end
  endtask

  // compare all outputs mid-cycle, then advance one clock and the model with it
  task automatic cycle(input string tag);
    #1;
    check({tag, ".rdat1"}, rdat1, exp_rd(int'(rsel1)));
    check({tag, ".rdat2"}, rdat2, exp_rd(int'(rsel2)));
    check({tag, ".stall"}, {31'h0, stall}, {31'h0, exp_haz(int'(rsel1)) | exp_haz(int'(rsel2))});
    check({tag, ".sb_err"}, {31'h0, sb_err}, {31'h0, m_err});
    @(posedge CLK);
    model_tick();
    @(negedge CLK);
  endtask

  task automatic idle();
    WEN = 0; wsel = 0; wdat = 0; issue_en = 0; issue_wr = 0; issue_dst = 0; sb_clr = 0;
  endtask

  initial begin
    nRST = 0; rsel1 = 0; rsel2 = 0;
    idle();
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1;

    // reset state
    rsel1 = 5; rsel2 = 0;
    #1;
    check("rst_rdat1", rdat1, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_sb_err", {31'h0, sb_err}, 32'h0);
    cycle("rst");

    // write-through bypass then array read
    WEN = 1; wsel = 8; wdat = 32'hDEADBEEF; rsel1 = 8;
    #1 check("bypass_r8", rdat1, 32'hDEADBEEF);
    cycle("bypass");
    WEN = 0;
    #1 check("array_r8", rdat1, 32'hDEADBEEF);
    cycle("array");

    // register 0 is never written nor bypassed
    WEN = 1; wsel = 0; wdat = 32'h1234; rsel1 = 0;
    #1 check("r0_wcycle", rdat1, 32'h0);
    cycle("r0w");
    WEN = 0;
    #1 check("r0_after", rdat1, 32'h0);
    cycle("r0r");

    // single pending writer retired by write-back
    issue_en = 1; issue_wr = 1; issue_dst = 3;
    cycle("iss3");
    idle(); rsel1 = 3;
    #1 check("haz3_stall", {31'h0, stall}, 32'h1);
    cycle("haz3a");
    cycle("haz3b");
    WEN = 1; wsel = 3; wdat = 32'd7;
    #1 check("wb3_stall", {31'h0, stall}, 32'h0);
    check("wb3_rdat1", rdat1, 32'd7);
    cycle("wb3");
    idle();
    #1 check("post3_stall", {31'h0, stall}, 32'h0);
    cycle("post3");

    // two pending writers on r4
    issue_en = 1; issue_wr = 1; issue_dst = 4; rsel1 = 4;
    cycle("iss4a");
    cycle("iss4b");
    idle(); WEN = 1; wsel = 4; wdat = 32'h44;
    #1 check("wb4a_stall", {31'h0, stall}, 32'h1);
    cycle("wb4a");
    wdat = 32'h45;
    #1 check("wb4b_stall", {31'h0, stall}, 32'h0);
    cycle("wb4b");
    idle();

    // overflow on r9, then flush keeps the sticky error
    rsel1 = 9; issue_en = 1; issue_wr = 1; issue_dst = 9;
    repeat (4) cycle("iss9");
    idle();
    #1 check("ovf_sb_err", {31'h0, sb_err}, 32'h1);
    check("ovf_stall", {31'h0, stall}, 32'h1);
    sb_clr = 1;
    cycle("clr");
    sb_clr = 0;
    #1 check("clr_stall", {31'h0, stall}, 32'h0);
    check("clr_sb_err", {31'h0, sb_err}, 32'h1);
    cycle("post_clr");

    // asynchronous reset between edges
    WEN = 1; wsel = 6; wdat = 32'hABC; issue_en = 1; issue_wr = 1; issue_dst = 5;
    cycle("pre_arst");
    idle(); rsel1 = 6; rsel2 = 5;
    nRST = 0;
    #1;
    check("arst_rdat1", rdat1, 32'h0);
    check("arst_stall", {31'h0, stall}, 32'h0);
    check("arst_sb_err", {31'h0, sb_err}, 32'h0);
    model_reset();
    @(negedge CLK);
    nRST = 1;
    cycle("post_arst");

    // randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 600; i++) begin
      WEN       = ($urandom % 3) == 0;
      wsel      = 5'($urandom % 8);
      wdat      = $urandom;
      issue_en  = ($urandom % 3) == 0;
      issue_wr  = ($urandom % 4) != 0;
      issue_dst = 5'($urandom % 8);
      sb_clr    = ($urandom % 40) == 0;
      rsel1     = ($urandom % 4 == 0) ? wsel : 5'($urandom % 8);
      rsel2     = 5'($urandom % 32);
      cycle("rnd");
    end
    idle();
    cycle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
